// File: rtl/sw_debounce8.sv
// Eight-channel switch debouncer: 2-flop synchronizer, per-channel stability counter,
// registered change mask/pulse and activity flag for a downstream priority encoder.
module sw_debounce8 #(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_in,
  input  logic       hold,
  output logic [7:0] x_out,
  output logic       any_active,
  output logic       chg_pulse,
  output logic [7:0] chg_mask
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [7:0]       sync1_q, sync1_d;
  logic [7:0]       sync2_q, sync2_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       chg_mask_q, chg_mask_d;
  logic             chg_pulse_q, chg_pulse_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    x_d     = x_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      // A channel only advances while it disagrees with its debounced level;
      // agreement or hold restarts the count from zero.
      if (!hold && (sync2_q[i] != x_q[i])) begin
        if (cnt_q[i] >= CNT_LAST) begin
          x_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    chg_mask_d  = x_d ^ x_q;
    chg_pulse_d = |chg_mask_d;
    any_d       = |x_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      x_q         <= '0;
      chg_mask_q  <= '0;
      chg_pulse_q <= 1'b0;
      any_q       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      x_q         <= x_d;
      chg_mask_q  <= chg_mask_d;
      chg_pulse_q <= chg_pulse_d;
      any_q       <= any_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign x_out      = x_q;
  assign chg_mask   = chg_mask_q;
  assign chg_pulse  = chg_pulse_q;
  assign any_active = any_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Bench for sw_debounce8 (DB_CYCLES=4): directed scenarios with fixed expectations,
// then randomized traffic checked every cycle against a streak-based reference model.
module tb_sw_debounce8;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_in;
  logic       hold;
  logic [7:0] x_out;
  logic       any_active;
  logic       chg_pulse;
  logic [7:0] chg_mask;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: synchronizer as a two-deep delay of sw_in; a channel flips once it has
  // seen DB consecutive unheld edges on which its delayed input disagreed with it.
  logic [7:0] m_s1, m_s2, m_x, m_mask;
  logic       m_pulse, m_any;
  int         m_streak [8];

  sw_debounce8 #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .hold       (hold),
    .x_out      (x_out),
    .any_active (any_active),
    .chg_pulse  (chg_pulse),
    .chg_mask   (chg_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [7:0] nx;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_x = '0; m_mask = '0; m_pulse = 1'b0; m_any = 1'b0;
      for (int i = 0; i < 8; i++) m_streak[i] = 0;
    end else begin
      nx = m_x;
      for (int i = 0; i < 8; i++) begin
        if (!hold && (m_s2[i] != m_x[i])) begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] == DB) begin
            nx[i] = m_s2[i];
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      m_mask  = nx ^ m_x;
      m_pulse = |m_mask;
      m_any   = |nx;
      m_x     = nx;
      m_s2    = m_s1;
      m_s1    = sw_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("x_out", x_out, m_x);
    chk("any_active", 8'(any_active), 8'(m_any));
    chk("chg_pulse", 8'(chg_pulse), 8'(m_pulse));
    chk("chg_mask", chg_mask, m_mask);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int pulses;
    rst = 1'b1; sw_in = 8'h00; hold = 1'b0;
    m_s1 = '0; m_s2 = '0; m_x = '0; m_mask = '0; m_pulse = 1'b0; m_any = 1'b0;
    for (int i = 0; i < 8; i++) m_streak[i] = 0;
    steps(2);
    chk("rst_x", x_out, 8'h00);
    chk("rst_any", 8'(any_active), 8'h00);
    chk("rst_pulse", 8'(chg_pulse), 8'h00);
    chk("rst_mask", chg_mask, 8'h00);

    // Idle with all switches open.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("idle_x", x_out, 8'h00);
      chk("idle_pulse", 8'(chg_pulse), 8'h00);
    end

    // Single rising channel: visible after the sixth edge.
    sw_in = 8'h80;
    steps(5);
    chk("rise_early_x", x_out, 8'h00);
    step();
    chk("rise_x", x_out, 8'h80);
    chk("rise_pulse", 8'(chg_pulse), 8'h01);
    chk("rise_mask", chg_mask, 8'h80);
    step();
    chk("rise_pulse_end", 8'(chg_pulse), 8'h00);
    chk("rise_any", 8'(any_active), 8'h01);

    sw_in = 8'h00;
    steps(10);
    chk("fall_x", x_out, 8'h00);

    // Two 3-cycle glitches separated by one low cycle: the count must restart.
    for (int g = 0; g < 2; g++) begin
      sw_in = 8'h08; steps(3);
      sw_in = 8'h00; steps(1);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (chg_pulse) pulses++;
    end
    chk("glitch_x", x_out, 8'h00);
    chk("glitch_pulses", 8'(pulses), 8'h00);

    // Two channels rising together give one pulse with both mask bits.
    sw_in = 8'h05;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (chg_pulse) pulses++;
    end
    step();
    chk("multi_mask", chg_mask, 8'h05);
    chk("multi_x", x_out, 8'h05);
    if (chg_pulse) pulses++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (chg_pulse) pulses++;
    end
    chk("multi_pulses", 8'(pulses), 8'h01);

    // Hold freezes output; after release a full count is needed.
    hold = 1'b1; sw_in = 8'h00;
    steps(10);
    chk("hold_x", x_out, 8'h05);
    hold = 1'b0;
    steps(3);
    chk("unhold_early_x", x_out, 8'h05);
    step();
    chk("unhold_x", x_out, 8'h00);
    chk("unhold_mask", chg_mask, 8'h05);

    // Reset mid-count discards progress; the full latency restarts afterwards.
    sw_in = 8'h80;
    steps(4);
    rst = 1'b1;
    step();
    chk("midrst_x", x_out, 8'h00);
    chk("midrst_pulse", 8'(chg_pulse), 8'h00);
    chk("midrst_any", 8'(any_active), 8'h00);
    rst = 1'b0;
    steps(5);
    chk("postrst_early_x", x_out, 8'h00);
    step();
    chk("postrst_x", x_out, 8'h80);
    chk("postrst_pulse", 8'(chg_pulse), 8'h01);

    // Randomized traffic: sticky levels, glitches, bursts, hold windows, rare resets.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)       sw_in = sw_in ^ (8'h01 << $urandom_range(0, 7));
      else if (r < 10) sw_in = 8'($urandom);
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; hold = 1'b0;
    steps(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
